// File: rtl/fifo_ctrl4x64.sv
// Pointer and flag controller for a 4-entry x 64-bit register-file FIFO buffer.
// Wrap-bit pointers give full/empty/count directly; the buffer itself lives beside this block.
module fifo_ctrl4x64 #(
  parameter int WIDTH       = 64,
  parameter int AW          = 2,
  parameter int AFULL_LEVEL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  output logic [AW-1:0]    buf_w_addr,
  output logic [WIDTH-1:0] buf_w_data,
  output logic             buf_w_enable,
  output logic [AW-1:0]    buf_r_addr,
  input  logic [WIDTH-1:0] buf_r_data
);

  localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LEVEL);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_accept;
  logic        pop_accept;

  always_comb begin
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    count       = wr_ptr - rd_ptr;
    almost_full = (count >= AFULL_CNT);
  end

  // Reset dominates, so neither request may strobe the buffer while rst is high.
  always_comb begin
    pop_accept  = pop & ~empty & ~rst;
    push_accept = push & (~full | pop_accept) & ~rst;
  end

  assign buf_w_addr   = wr_ptr[AW-1:0];
  assign buf_w_data   = push_data;
  assign buf_w_enable = push_accept;
  assign buf_r_addr   = rd_ptr[AW-1:0];
  assign pop_data     = buf_r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_accept)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Sticky error flags; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full & ~pop_accept) overflow  <= 1'b1;
      if (pop & empty)               underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl4x64.sv
// Bench for fifo_ctrl4x64: a register-file buffer model plus a queue-based reference
// of the FIFO, driven by directed steps followed by random traffic.
module tb_fifo_ctrl4x64;

  localparam int WIDTH = 64;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;
  logic [AW-1:0]    buf_w_addr;
  logic [WIDTH-1:0] buf_w_data;
  logic             buf_w_enable;
  logic [AW-1:0]    buf_r_addr;
  logic [WIDTH-1:0] buf_r_data;

  fifo_ctrl4x64 #(.WIDTH(WIDTH), .AW(AW), .AFULL_LEVEL(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_data     (pop_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .buf_w_addr   (buf_w_addr),
    .buf_w_data   (buf_w_data),
    .buf_w_enable (buf_w_enable),
    .buf_r_addr   (buf_r_addr),
    .buf_r_data   (buf_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The register-file buffer that sits beside the controller.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) if (buf_w_enable) mem[buf_w_addr] <= buf_w_data;
  assign buf_r_data = mem[buf_r_addr];

  // Reference model: a plain queue of words plus slot counters and sticky flags.
  logic [WIDTH-1:0] mdl_q [$];
  int  mdl_wr_slot;
  int  mdl_rd_slot;
  bit  mdl_ovf;
  bit  mdl_unf;

  int compares;
  int fails;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compares++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkState();
    int n;
    n = mdl_q.size();
    checkOutput("count", 64'(count), 64'(n));
    checkOutput("empty", 64'(empty), 64'(n == 0));
    checkOutput("full", 64'(full), 64'(n == DEPTH));
    checkOutput("almost_full", 64'(almost_full), 64'(n >= 3));
    checkOutput("overflow", 64'(overflow), 64'(mdl_ovf));
    checkOutput("underflow", 64'(underflow), 64'(mdl_unf));
    checkOutput("buf_r_addr", 64'(buf_r_addr), 64'(mdl_rd_slot));
    if (n > 0) checkOutput("pop_data", pop_data, mdl_q[0]);
  endtask

  // Drive one cycle of requests, check the write-side strobes before the edge,
  // then advance the model and check the registered state after the edge.
  task automatic applyStimulus(input bit p, input logic [WIDTH-1:0] d, input bit pp, input bit r);
    int  n;
    bit  pop_ok;
    bit  push_ok;
    push      = p;
    push_data = d;
    pop       = pp;
    rst       = r;
    #1;
    n       = mdl_q.size();
    pop_ok  = !r && pp && (n > 0);
    push_ok = !r && p && ((n < DEPTH) || pop_ok);
    checkOutput("buf_w_enable", 64'(buf_w_enable), 64'(push_ok));
    checkOutput("buf_w_data", buf_w_data, d);
    if (push_ok) checkOutput("buf_w_addr", 64'(buf_w_addr), 64'(mdl_wr_slot));
    @(posedge clk);
    #1;
    if (r) begin
      mdl_q.delete();
      mdl_wr_slot = 0;
      mdl_rd_slot = 0;
      mdl_ovf     = 0;
      mdl_unf     = 0;
    end else begin
      if (p && n == DEPTH && !pop_ok) mdl_ovf = 1;
      if (pp && n == 0) mdl_unf = 1;
      if (pop_ok) begin
        void'(mdl_q.pop_front());
        mdl_rd_slot = (mdl_rd_slot + 1) % DEPTH;
      end
      if (push_ok) begin
        mdl_q.push_back(d);
        mdl_wr_slot = (mdl_wr_slot + 1) % DEPTH;
      end
    end
    checkState();
  endtask

  initial begin
    compares    = 0;
    fails       = 0;
    mdl_wr_slot = 0;
    mdl_rd_slot = 0;
    mdl_ovf     = 0;
    mdl_unf     = 0;
    push        = 0;
    pop         = 0;
    push_data   = '0;
    rst         = 1;

    $display("[TB] reset then idle");
    applyStimulus(0, 64'h0, 0, 1);
    applyStimulus(0, 64'h0, 0, 1);
    applyStimulus(0, 64'h0, 0, 0);

    $display("[TB] fill");
    applyStimulus(1, 64'h11, 0, 0);
    applyStimulus(1, 64'h22, 0, 0);
    applyStimulus(1, 64'h33, 0, 0);
    applyStimulus(1, 64'h44, 0, 0);

    $display("[TB] overflow then drain");
    applyStimulus(1, 64'h55, 0, 0);
    applyStimulus(0, 64'h0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 64'h0, 1, 0);

    $display("[TB] wrap with simultaneous push/pop");
    applyStimulus(1, 64'hA0, 0, 0);
    for (int i = 1; i < 6; i++) applyStimulus(1, 64'hA0 + 64'(i), 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 64'hB0 + 64'(i), 0, 0);
    applyStimulus(1, 64'hBB, 1, 0);

    $display("[TB] underflow and empty corner");
    for (int i = 0; i < 4; i++) applyStimulus(0, 64'h0, 1, 0);
    applyStimulus(0, 64'h0, 1, 0);
    applyStimulus(1, 64'hCC, 1, 0);
    applyStimulus(0, 64'h0, 0, 0);

    $display("[TB] mid-operation reset");
    applyStimulus(1, 64'hD1, 0, 0);
    applyStimulus(1, 64'hD2, 0, 0);
    applyStimulus(1, 64'hD3, 0, 1);
    applyStimulus(0, 64'h0, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 60), {$urandom, $urandom},
                    ($urandom_range(0, 99) < 50), ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
